mmu_skew_feeder: RTL and testbench

- Upstream stage of the MMU systolic array's west edge.
- Accepts an N×N operand tile row by row over a valid/ready handshake and stores it in an internal buffer.
- Then streams it into N lanes with diagonal skew: lane r starts r cycles after lane 0, which gives the wavefront timing the PE array needs.
- Supports a downstream stall and reports busy/done to the tile sequencer.

---
 rtl/mmu_skew_feeder.sv | 101 ++++++++++
 tb/tb_mmu_skew_feeder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mmu_skew_feeder.sv
// rtl/mmu_skew_feeder.sv - tile buffer that feeds the MMU west edge with a diagonal skew
// Loads an NxN tile row by row, then streams lane r delayed r cycles behind lane 0.
module mmu_skew_feeder #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*N-1:0] in_row,
  input  logic           stall,
  output logic [W*N-1:0] lane_data,
  output logic [N-1:0]   lane_valid,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N);
  localparam int SW = $clog2(2*N-1) + 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(2*N-2);
  localparam logic [CW-1:0] LAST_ROW  = CW'(N-1);

  typedef enum logic [1:0] {S_LOAD, S_STREAM, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   row_cnt;
  logic [SW-1:0]   step;
  logic [W-1:0]    mem [N][N];
  logic [W*N-1:0]  nxt_data;
  logic [N-1:0]    nxt_valid;

  // Buffer has no reset: contents only matter after a full tile is written.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) begin
      for (int c = 0; c < N; c++) begin
        mem[row_cnt][c] <= in_row[W*c +: W];
      end
    end
  end

  // Lane r is live while step lies in [r, r+N-1]; compares avoid any negative wrap.
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic          hit;
    logic [CW-1:0] col;
    assign hit = (step >= SW'(r)) && (step < SW'(r + N));
    assign col = CW'(step - SW'(r));
    assign nxt_valid[r]          = hit;
    assign nxt_data[W*r +: W]    = hit ? mem[r][col] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LOAD;
      row_cnt    <= '0;
      step       <= '0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      lane_data  <= '0;
      lane_valid <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          if (in_valid) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt  <= '0;
              step     <= '0;
              state    <= S_STREAM;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              row_cnt <= row_cnt + CW'(1);
            end
          end
        end
        S_STREAM: begin
          if (!stall) begin
            lane_data  <= nxt_data;
            lane_valid <= nxt_valid;
            step       <= step + SW'(1);
            if (step == LAST_STEP) state <= S_DONE;
          end
        end
        S_DONE: begin
          // busy stays high through the done cycle and drops with it.
          lane_data  <= '0;
          lane_valid <= '0;
          done       <= 1'b1;
          in_ready   <= 1'b1;
          state      <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_skew_feeder.sv
// tb/tb_mmu_skew_feeder.sv - directed bench for mmu_skew_feeder (N=4, W=16)
// Loads tiles, checks skewed lane outputs, stall, gaps, back-to-back and reset abort.
module tb_mmu_skew_feeder;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W*N-1:0] in_row;
  logic           stall;
  logic [W*N-1:0] lane_data;
  logic [N-1:0]   lane_valid;
  logic           busy;
  logic           done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0]   a [N][N];
  logic [W*N-1:0] hist [2*N-1];

  mmu_skew_feeder #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .stall(stall), .lane_data(lane_data), .lane_valid(lane_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_tile(input logic [15:0] base);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        a[r][c] = base + 16'(16*r + c);
  endtask

  function automatic logic [W*N-1:0] row_of(input int r);
    logic [W*N-1:0] v;
    for (int c = 0; c < N; c++) v[W*c +: W] = a[r][c];
    return v;
  endfunction

  // Called at a negedge; returns at the negedge right after the last row is accepted.
  task automatic send_rows(input bit gaps);
    for (int r = 0; r < N; r++) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_row   = row_of(r);
      @(negedge clk);
      if (gaps && r < N-1) begin
        in_valid = 1'b0;
        in_row   = '1;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_row   = '0;
  endtask

  // Checks every output cycle against the tile model; returns at the negedge of the done cycle.
  task automatic stream_check(input int stall_at, input int stall_len, input bit junk, input int abort_at);
    int k = 0;
    int cyc = 0;
    int stalled = 0;
    logic [W*N-1:0] ed;
    logic [N-1:0]   ev;
    if (junk) begin
      in_valid = 1'b1;
      in_row   = {N{16'hDEAD}};
    end
    while (k < 2*N-1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      ed = '0;
      ev = '0;
      for (int r = 0; r < N; r++) begin
        if (k >= r && k - r < N) begin
          ev[r]          = 1'b1;
          ed[W*r +: W]   = a[r][k-r];
        end
      end
      hist[k] = lane_data;
      chk("lane_data", lane_data, ed);
      chk("lane_valid", lane_valid, ev);
      chk("busy_stream", busy, 1);
      chk("done_early", done, 0);
      chk("in_ready_stream", in_ready, 0);
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_lane_valid", lane_valid, 0);
        chk("abort_lane_data", lane_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready", in_ready, 1);
        stall    = 1'b0;
        in_valid = 1'b0;
        return;
      end
      if (k == stall_at && stalled < stall_len) begin
        stall = 1'b1;
        stalled++;
      end else begin
        stall = 1'b0;
        k++;
      end
    end
    in_valid = 1'b0;
    in_row   = '0;
    stall    = 1'b0;
    chk("stream_cycles", cyc, 2*N-1+stall_len);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    chk("in_ready_in_done", in_ready, 1);
    chk("lane_valid_cleared", lane_valid, 0);
    chk("lane_data_cleared", lane_data, 0);
  endtask

  task automatic after_done;
    @(negedge clk);
    chk("done_fell", done, 0);
    chk("busy_fell", busy, 0);
    chk("in_ready_idle", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_row = '0; stall = 1'b0;

    // Asynchronous reset with no clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lane_valid", lane_valid, 0);
    chk("rst_lane_data", lane_data, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);

    // Basic tile
    set_tile(16'h0000);
    send_rows(1'b0);
    stream_check(-1, 0, 1'b0, -1);
    chk("hand_step1", hist[1], 64'h0000_0000_0010_0001);
    chk("hand_step3", hist[3], 64'h0030_0021_0012_0003);
    chk("hand_step6", hist[6], 64'h0033_0000_0000_0000);
    after_done;

    // Handshake gaps, junk offered during streaming
    set_tile(16'h1000);
    send_rows(1'b1);
    stream_check(-1, 0, 1'b1, -1);
    after_done;

    // Stall at step 2 for 3 cycles, then tile B back-to-back
    set_tile(16'h0000);
    send_rows(1'b0);
    stream_check(2, 3, 1'b0, -1);
    chk("hand_stall_step2", hist[2], 64'h0000_0020_0011_0002);
    set_tile(16'hB000);
    send_rows(1'b0);
    stream_check(-1, 0, 1'b0, -1);
    chk("b2b_first", hist[0], 64'h0000_0000_0000_B000);
    after_done;

    // Reset at step 4, then a full tile
    set_tile(16'h2000);
    send_rows(1'b0);
    stream_check(-1, 0, 1'b0, 4);
    @(negedge clk); rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_done_after_abort", done, 0);
      chk("idle_after_abort", busy, 0);
    end
    set_tile(16'h3000);
    send_rows(1'b0);
    stream_check(-1, 0, 1'b0, -1);
    after_done;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
